// File: rtl/i2s_frame_transmitter_if.sv
// Sample-pair handshake and serial pin bundle for the I2S frame transmitter.
// The master side is the sample producer. The slave side is the transmitter.
interface i2s_frame_transmitter_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] data_left;
   logic [DATA_WIDTH-1:0] data_right;
   logic                  in_valid;
   logic                  in_ready;
   logic                  sck;
   logic                  ws;
   logic                  sd;
   logic                  underrun;

   modport master (
      output data_left, data_right, in_valid,
      input  in_ready, sck, ws, sd, underrun
   );

   modport slave (
      input  data_left, data_right, in_valid,
      output in_ready, sck, ws, sd, underrun
   );
endinterface

// File: rtl/i2s_frame_transmitter.sv
// Stereo I2S / left-justified serial transmitter.
// SCK and WS are derived from clk. A one-entry buffer holds the next sample pair,
// which is loaded into a frame shift register at each frame start.
module i2s_frame_transmitter #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int CLK_DIV    = 4,
   parameter int I2S_MODE   = 1
) (
   input logic                     clk,
   input logic                     rst,
   i2s_frame_transmitter_if.slave  bus
);
   localparam int FRAME = 2 * SLOT_WIDTH;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int IDX_W = $clog2(FRAME);

   logic [DIV_W-1:0]      r_div;
   logic                  r_sck;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_ws;
   logic                  r_sd;
   logic                  r_prev_last;
   logic [FRAME-1:0]      r_shift;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_buf_l;
   logic [DATA_WIDTH-1:0] r_buf_r;
   logic                  r_underrun;

   logic                  w_wrap;
   logic                  w_fall;
   logic                  w_start;
   logic                  w_capture;
   logic [IDX_W-1:0]      w_idx_next;
   logic [FRAME-1:0]      w_frame;

   assign w_wrap     = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_fall     = w_wrap & r_sck;
   assign w_idx_next = (r_idx == IDX_W'(FRAME - 1)) ? '0 : r_idx + IDX_W'(1);
   assign w_start    = w_fall & (w_idx_next == '0);
   assign w_capture  = bus.in_valid & ~r_full;

   // Next frame image, MSB = first bit on the wire; zeros when the buffer is empty
   always_comb begin
      w_frame = '0;
      if (r_full) begin
         w_frame[FRAME-1 -: DATA_WIDTH]      = r_buf_l;
         w_frame[SLOT_WIDTH-1 -: DATA_WIDTH] = r_buf_r;
      end
   end

   // SCK generator: divider wraps every CLK_DIV cycles and toggles SCK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
         r_sck <= 1'b0;
      end else if (w_wrap) begin
         r_div <= '0;
         r_sck <= ~r_sck;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Bit sequencer: advance bit index, WS and SD on each SCK falling event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= IDX_W'(FRAME - 1);
         r_ws        <= 1'b0;
         r_sd        <= 1'b0;
         r_prev_last <= 1'b0;
         r_shift     <= '0;
      end else if (w_fall) begin
         r_idx <= w_idx_next;
         r_ws  <= (w_idx_next >= IDX_W'(SLOT_WIDTH));
         if (w_start) begin
            r_prev_last <= w_frame[0];
            // I2S delays the stream by one bit: slot 0 carries the previous frame's last bit
            if (I2S_MODE != 0) begin
               r_sd    <= r_prev_last;
               r_shift <= w_frame;
            end else begin
               r_sd    <= w_frame[FRAME-1];
               r_shift <= w_frame << 1;
            end
         end else begin
            r_sd    <= r_shift[FRAME-1];
            r_shift <= r_shift << 1;
         end
      end
   end

   // Holding buffer: capture on handshake, drain at frame start, flag underruns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full     <= 1'b0;
         r_buf_l    <= '0;
         r_buf_r    <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_start & ~r_full;
         if (w_capture) begin
            r_full  <= 1'b1;
            r_buf_l <= bus.data_left;
            r_buf_r <= bus.data_right;
         end else if (w_start) begin
            r_full <= 1'b0;
         end
      end
   end

   assign bus.in_ready = ~r_full;
   assign bus.sck      = r_sck;
   assign bus.ws       = r_ws;
   assign bus.sd       = r_sd;
   assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_i2s_frame_transmitter.sv
// Self-checking bench for i2s_frame_transmitter: three configurations, each
// compared cycle by cycle against a frame-level reference model.
module tb_i2s_frame_transmitter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic rst_c = 1'b1;

   i2s_frame_transmitter_if #(.DATA_WIDTH(24)) bus_a ();
   i2s_frame_transmitter_if #(.DATA_WIDTH(16)) bus_b ();
   i2s_frame_transmitter_if #(.DATA_WIDTH(16)) bus_c ();

   i2s_frame_transmitter #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .CLK_DIV(2), .I2S_MODE(1))
      u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   i2s_frame_transmitter #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .CLK_DIV(2), .I2S_MODE(0))
      u_b (.clk(clk), .rst(rst_b), .bus(bus_b));
   i2s_frame_transmitter #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .CLK_DIV(2), .I2S_MODE(1))
      u_c (.clk(clk), .rst(rst_c), .bus(bus_c));

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_sel, m_dw, m_sw, m_cd, m_i2s, m_n;
   bit m_rst;
   bit m_full;
   logic [31:0] m_bl, m_br;
   bit m_s [64];
   bit e_sck, e_ws, e_sd, e_rdy, e_und, e_fall, e_start, acc;
   int e_k;
   logic [4:0] obs, exp_v;

   task automatic model_clear();
      m_n = 0; m_full = 0;
      for (int i = 0; i < 64; i++) m_s[i] = 0;
      e_sck = 0; e_ws = 0; e_sd = 0; e_rdy = 1; e_und = 0;
      e_fall = 0; e_start = 0; acc = 0; e_k = -1;
   endtask

   task automatic select_cfg(input int sel);
      m_sel = sel;
      case (sel)
         0: begin m_dw = 24; m_sw = 32; m_cd = 2; m_i2s = 1; end
         1: begin m_dw = 16; m_sw = 16; m_cd = 2; m_i2s = 0; end
         default: begin m_dw = 16; m_sw = 16; m_cd = 2; m_i2s = 1; end
      endcase
   endtask

   task automatic set_rst(input int sel, input logic val);
      case (sel)
         0: rst_a = val;
         1: rst_b = val;
         default: rst_c = val;
      endcase
   endtask

   task automatic drive(input bit v, input logic [31:0] l, input logic [31:0] r);
      case (m_sel)
         0: begin bus_a.in_valid = v; bus_a.data_left = l[23:0]; bus_a.data_right = r[23:0]; end
         1: begin bus_b.in_valid = v; bus_b.data_left = l[15:0]; bus_b.data_right = r[15:0]; end
         default: begin bus_c.in_valid = v; bus_c.data_left = l[15:0]; bus_c.data_right = r[15:0]; end
      endcase
   endtask

   task automatic sample();
      case (m_sel)
         0: obs = {bus_a.sck, bus_a.ws, bus_a.sd, bus_a.in_ready, bus_a.underrun};
         1: obs = {bus_b.sck, bus_b.ws, bus_b.sd, bus_b.in_ready, bus_b.underrun};
         default: obs = {bus_c.sck, bus_c.ws, bus_c.sd, bus_c.in_ready, bus_c.underrun};
      endcase
      exp_v = {e_sck, e_ws, e_sd, e_rdy, e_und};
   endtask

   // Frame-level model: SCK phase and bit position follow from the edge count.
   task automatic model_step(input bit v, input logic [31:0] l, input logic [31:0] r);
      bit was_full, last;
      if (m_rst) begin
         model_clear();
         return;
      end
      was_full = m_full;
      m_n++;
      e_sck   = ((m_n / m_cd) % 2) == 1;
      e_fall  = (m_n % (2 * m_cd)) == 0;
      e_start = 0;
      acc     = v && !was_full;
      if (e_fall) begin
         e_k  = (m_n / (2 * m_cd) - 1) % (2 * m_sw);
         e_ws = (e_k >= m_sw);
         if (e_k == 0) begin
            e_start = 1;
            last = m_s[2 * m_sw - 1];
            for (int i = 0; i < 64; i++) m_s[i] = 0;
            if (was_full) begin
               for (int i = 0; i < m_dw; i++) begin
                  m_s[i]        = m_bl[m_dw - 1 - i];
                  m_s[m_sw + i] = m_br[m_dw - 1 - i];
               end
            end
            e_sd = (m_i2s != 0) ? last : m_s[0];
         end else begin
            e_sd = (m_i2s != 0) ? m_s[e_k - 1] : m_s[e_k];
         end
      end
      e_und = e_start && !was_full;
      if (acc) begin
         m_full = 1; m_bl = l; m_br = r;
      end else if (e_start && was_full) begin
         m_full = 0;
      end
      e_rdy = !m_full;
   endtask

   task automatic tick(input bit v, input logic [31:0] l, input logic [31:0] r);
      drive(v, l, r);
      @(posedge clk);
      #1;
      model_step(v, l, r);
      sample();
   endtask

   task automatic idle_all();
      bus_a.in_valid = 0; bus_a.data_left = '0; bus_a.data_right = '0;
      bus_b.in_valid = 0; bus_b.data_left = '0; bus_b.data_right = '0;
      bus_c.in_valid = 0; bus_c.data_left = '0; bus_c.data_right = '0;
   endtask

   task automatic hold_reset(input int sel);
      select_cfg(sel);
      set_rst(sel, 1'b1);
      m_rst = 1;
      model_clear();
      idle_all();
      tick(0, '0, '0);
      tick(0, '0, '0);
      set_rst(sel, 1'b0);
      m_rst = 0;
   endtask

   task automatic test_reset();
      select_cfg(0);
      set_rst(0, 1'b1);
      m_rst = 1;
      model_clear();
      idle_all();
      for (int i = 0; i < 4; i++) begin
         tick(0, '0, '0);
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_hold n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
      set_rst(0, 1'b0);
      m_rst = 0;
      for (int i = 0; i < 16; i++) begin
         tick(0, '0, '0);
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL clock_startup n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
   endtask

   task automatic test_i2s_frame();
      int fr;
      logic [23:0] got_l, got_r;
      hold_reset(0);
      fr = 0; got_l = '0; got_r = '0;
      tick(1, 32'h00A5A5A5, 32'h003C3C3C);
      for (int i = 0; i < 2 * 256 + 8; i++) begin
         if (i > 0) tick(0, '0, '0);
         if (e_start) fr++;
         if (e_fall && fr == 1 && e_k >= 1 && e_k <= 24) got_l = {got_l[22:0], obs[2]};
         if (e_fall && fr == 1 && e_k >= 33 && e_k <= 56) got_r = {got_r[22:0], obs[2]};
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL i2s_frame n=%0d k=%0d got=%b exp=%b", m_n, e_k, obs, exp_v);
         end
         vectors++;
      end
      if (got_l !== 24'hA5A5A5) begin
         miscompares++;
         $display("FAIL i2s_left_word got=%h exp=a5a5a5", got_l);
      end
      vectors++;
      if (got_r !== 24'h3C3C3C) begin
         miscompares++;
         $display("FAIL i2s_right_word got=%h exp=3c3c3c", got_r);
      end
      vectors++;
   endtask

   task automatic test_underrun();
      int pulses;
      bit sent;
      pulses = 0;
      for (int i = 0; i < 2 * 256; i++) begin
         tick(0, '0, '0);
         if (obs[0]) pulses++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL underrun_idle n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
      if (pulses !== 2) begin
         miscompares++;
         $display("FAIL underrun_pulses got=%0d exp=2", pulses);
      end
      vectors++;
      sent = 0;
      for (int i = 0; i < 3 * 256; i++) begin
         tick(!sent && i == 40, $urandom(), $urandom());
         if (acc) sent = 1;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL underrun_recover n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      int cnt;
      base = $urandom();
      cnt = 0;
      for (int i = 0; i < 4 * 256; i++) begin
         tick(1, base + cnt, ~(base + cnt));
         if (acc) cnt++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL back_to_back n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
      tick(0, '0, '0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6 * 256; i++) begin
         tick($urandom_range(0, 299) == 0, $urandom(), $urandom());
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL random_traffic n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int guard, pulses;
      bit found;
      hold_reset(0);
      tick(1, $urandom(), $urandom());
      tick(0, '0, '0);
      tick(1, $urandom(), $urandom());
      found = 0;
      guard = 0;
      while (!found && guard < 1000) begin
         tick(0, '0, '0);
         guard++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pre_reset n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
         if (e_fall && e_k == 10) found = 1;
      end
      if (!found) begin
         miscompares++;
         $display("FAIL reach_bit10 got=timeout exp=bit_idx_10");
      end
      vectors++;
      for (int i = 0; i < m_cd; i++) tick(0, '0, '0);
      #2;
      set_rst(0, 1'b1);
      #1;
      sample();
      if (obs !== 5'b00010) begin
         miscompares++;
         $display("FAIL async_reset got=%b exp=00010", obs);
      end
      vectors++;
      m_rst = 1;
      model_clear();
      tick(0, '0, '0);
      tick(0, '0, '0);
      set_rst(0, 1'b0);
      m_rst = 0;
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         tick(0, '0, '0);
         if (i < 10 && obs[0]) pulses++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL post_reset n=%0d got=%b exp=%b", m_n, obs, exp_v);
         end
         vectors++;
      end
      if (pulses !== 1) begin
         miscompares++;
         $display("FAIL post_reset_underrun got=%0d exp=1", pulses);
      end
      vectors++;
      idle_all();
   endtask

   task automatic test_full_width(input int sel);
      int fr;
      bit b0, b15, b16, nb0;
      hold_reset(sel);
      fr = 0; b0 = 0; b15 = 0; b16 = 1; nb0 = 1;
      tick(1, 32'h8001, 32'h7FFE);
      for (int i = 0; i < 2 * 128 + 8; i++) begin
         if (i > 0) tick(0, '0, '0);
         if (e_start) fr++;
         if (e_fall && fr == 1 && e_k == 0) b0 = obs[2];
         if (e_fall && fr == 1 && e_k == 15) b15 = obs[2];
         if (e_fall && fr == 1 && e_k == 16) b16 = obs[2];
         if (e_fall && fr == 2 && e_k == 0) nb0 = obs[2];
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL full_width cfg=%0d n=%0d got=%b exp=%b", sel, m_n, obs, exp_v);
         end
         vectors++;
      end
      if (sel == 1) begin
         if ({b0, b15, b16} !== 3'b110) begin
            miscompares++;
            $display("FAIL lj_bits got=%b exp=110", {b0, b15, b16});
         end
         vectors++;
      end else begin
         if ({b15, b16, nb0} !== 3'b010) begin
            miscompares++;
            $display("FAIL i2s16_bits got=%b exp=010", {b15, b16, nb0});
         end
         vectors++;
      end
      for (int i = 0; i < 4 * 128; i++) begin
         tick(1, $urandom(), $urandom() | 32'h1);
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL full_width_rand cfg=%0d n=%0d got=%b exp=%b", sel, m_n, obs, exp_v);
         end
         vectors++;
      end
      tick(0, '0, '0);
      set_rst(sel, 1'b1);
   endtask

   initial begin
      idle_all();
      m_rst = 1;
      model_clear();
      test_reset();
      test_i2s_frame();
      test_underrun();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      test_full_width(1);
      test_full_width(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end
endmodule
